multiplicador_seq: RTL and testbench

- Parametrised sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
- Processes one multiplier bit per clock through a single WIDTH-bit adder. This trades latency for area against the combinational cascade multiplier.
- Sits in the datapath beside the combinational arithmetic blocks and is driven by a controlling FSM through a start/done handshake.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/somador_nbits.sv | 24 ++
 rtl/multiplicador_seq.sv | 132 +++++++++++++
 tb/tb_multiplicador_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier datapath.
// Consumed by multiplicador_seq (optional macro there: MULT_SIGNED_EN).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Edges from the accepting start edge to the first edge with done visible, inclusive.
    function automatic int MULT_LATENCY(input int width);
        return width + 2;
    endfunction

    function automatic int mult_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/somador_nbits.sv
// Parametrised ripple-carry adder: {cout, sum} = a + b + cin.
module somador_nbits #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    always_comb begin
        logic [WIDTH:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[WIDTH];
    end

endmodule

// File: rtl/multiplicador_seq.sv
// Shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module multiplicador_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CW = mult_clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               load, step, finish;

    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH-1:0]   add_s;
    logic               add_c;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [2*WIDTH-1:0] result;

    somador_nbits #(.WIDTH(WIDTH)) u_step_add (
        .sum  (sum),
        .cout (cout),
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (a_reg),
        .cin  (1'b0)
    );

`ifdef MULT_SIGNED_EN
    logic               sign_q;
    logic [2*WIDTH-1:0] acc_neg;
    logic               neg_cout;

    // Magnitudes fit WIDTH unsigned bits, including the most-negative operand.
    assign a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign b_in = B[WIDTH-1] ? (~B + 1'b1) : B;

    somador_nbits #(.WIDTH(2*WIDTH)) u_negate (
        .sum  (acc_neg),
        .cout (neg_cout),
        .a    (~acc),
        .b    ('0),
        .cin  (1'b1)
    );

    assign result = sign_q ? acc_neg : acc;

    always_ff @(posedge clk) begin
        if (rst)       sign_q <= 1'b0;
        else if (load) sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
    end
`else
    assign a_in   = A;
    assign b_in   = B;
    assign result = acc;
`endif

    assign add_s = acc[0] ? sum  : acc[2*WIDTH-1:WIDTH];
    assign add_c = acc[0] ? cout : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // CALC holds one extra cycle after the last shift; P is loaded on the way into DONE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            if (load) begin
                a_reg <= a_in;
                acc   <= {{WIDTH{1'b0}}, b_in};
                cnt   <= '0;
            end else if (step) begin
                acc <= {add_c, add_s, acc[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
            if (finish) P <= result;
        end
    end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Scoreboard bench for multiplicador_seq at WIDTH=4 and WIDTH=8 (honours MULT_SIGNED_EN).
module tb_multiplicador_seq;
    import mult_pkg::*;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q4[$];
    logic [15:0] exp_q8[$];
    logic [7:0]  last4;
    logic [15:0] last8;

    multiplicador_seq #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .P(p4)
    );

    multiplicador_seq #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .P(p8)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b);
        int r;
`ifdef MULT_SIGNED_EN
        r = int'($signed(a)) * int'($signed(b));
`else
        r = int'(a) * int'(b);
`endif
        return r[7:0];
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
        int r;
`ifdef MULT_SIGNED_EN
        r = int'($signed(a)) * int'($signed(b));
`else
        r = int'(a) * int'(b);
`endif
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        #1;
        if (done4 === 1'b1) begin
            if (exp_q4.size() == 0) check_eq("spurious_done4", done4, 1'b0);
            else                    check_eq("p4", p4, exp_q4.pop_front());
        end
        if (done8 === 1'b1) begin
            if (exp_q8.size() == 0) check_eq("spurious_done8", done8, 1'b0);
            else                    check_eq("p8", p8, exp_q8.pop_front());
        end
    end

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        exp_q4.push_back(model4(a, b));
        last4 = model4(a, b);
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        check_eq("busy_calc4", busy4, 1'b1);
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check_eq("lat4", n, MULT_LATENCY(W4) - 1);
        check_eq("busy_done4", busy4, 1'b1);
        @(posedge clk); #1;
        check_eq("done_pulse4", done4, 1'b0);
        check_eq("idle4", busy4, 1'b0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        exp_q8.push_back(model8(a, b));
        last8 = model8(a, b);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check_eq("lat8", n, MULT_LATENCY(W8) - 1);
        @(posedge clk); #1;
        check_eq("done_pulse8", done8, 1'b0);
    endtask

    initial begin
        int n;
        int cnt;
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_busy4", busy4, 1'b0);
        check_eq("rst_done4", done4, 1'b0);
        check_eq("rst_p4", p4, 8'h00);
        check_eq("rst_busy8", busy8, 1'b0);
        check_eq("rst_p8", p8, 16'h0000);
        start4 = 1'b0;
        rst = 1'b0;

        run4(4'hF, 4'hF);
        run4(4'h0, 4'h9);
        run4(4'h9, 4'h0);
        run4(4'h8, 4'h8);
        run4(4'h8, 4'h7);
        run4(4'hF, 4'h1);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run4(4'(i), 4'(j));

        repeat (3) @(posedge clk);
        #1;
        check_eq("hold4", p4, last4);

        // start held through the whole operation with different operands
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        exp_q4.push_back(model4(4'hF, 4'hF));
        @(posedge clk); #1;
        a4 = 4'h3; b4 = 4'h2;
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check_eq("lat_held_start4", n, MULT_LATENCY(W4) - 1);
        start4 = 1'b0;
        cnt = 0;
        repeat (W4 + 4) begin @(posedge clk); #1; if (done4 === 1'b1) cnt++; end
        check_eq("ignored_start_dones", cnt, 0);
        run4(4'h3, 4'h2);

        // reset during the second CALC cycle
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_p4", p4, 8'h00);
        check_eq("abort_busy4", busy4, 1'b0);
        check_eq("abort_done4", done4, 1'b0);
        cnt = 0;
        repeat (W4 + 4) begin @(posedge clk); #1; if (done4 === 1'b1) cnt++; end
        check_eq("abort_dones", cnt, 0);
        run4(4'h3, 4'h5);

        run8(8'hFF, 8'hFF);
        run8(8'h00, 8'd200);
        run8(8'd200, 8'h00);
        run8(8'h80, 8'h80);
        repeat (20) run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold8", p8, last8);

        check_eq("q4_drained", exp_q4.size(), 0);
        check_eq("q8_drained", exp_q8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
